// File: rtl/sync_down_counter_4bit.sv
// -----------------------------------------------------------------------------
// sync_down_counter_4bit
//
// 4-bit synchronous down-counter. Each falling edge on the asynchronous Count
// input is synchronized into the CLK domain and then decrements the counter by
// one. When the counter underflows it either wraps to 1111 or reloads from D,
// depending on Auto_Reload, and Borrow pulses high for one cycle.
//
// Ports
//   CLK          in   system clock; every state change is on its rising edge
//   Reset        in   synchronous active-high reset
//   Count        in   asynchronous pulse stream; each falling edge = one event
//   Load         in   synchronous parallel-load strobe (A <= D)
//   D3..D0       in   load / reload value, D3 = MSB (synchronous to CLK)
//   Auto_Reload  in   1: reload from D on underflow, 0: wrap to 1111
//   A3..A0       out  registered count, A3 = MSB
//   Borrow       out  registered one-cycle underflow pulse
//   Zero         out  combinational, high while A == 0000
//
// Parameter
//   SYNC_STAGES  flip-flop depth of the Count synchronizer (2 or 3)
// -----------------------------------------------------------------------------
module sync_down_counter_4bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic Reset,
    input  logic Count,
    input  logic Load,
    input  logic D3,
    input  logic D2,
    input  logic D1,
    input  logic D0,
    input  logic Auto_Reload,
    output logic A3,
    output logic A2,
    output logic A1,
    output logic A0,
    output logic Borrow,
    output logic Zero
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic [3:0]             count_q;
    logic [3:0]             count_d;
    logic                   borrow_q;
    logic                   borrow_d;
    logic [3:0]             d_val;
    logic                   dec_event;

    assign d_val = {D3, D2, D1, D0};

    // Falling edge of the synchronized Count: history still high, newest low.
    // Clearing hist on reset means a Count held high through reset first has to
    // be seen high after reset before its fall can register as an event.
    assign dec_event = hist & ~sync[SYNC_STAGES-1];

    always_comb begin
        count_d  = count_q;
        borrow_d = 1'b0;
        if (Load) begin
            // Load wins over a coincident event; that event is simply dropped.
            count_d = d_val;
        end else if (dec_event) begin
            if (count_q == 4'b0000) begin
                borrow_d = 1'b1;
                count_d  = Auto_Reload ? d_val : 4'b1111;
            end else begin
                count_d = count_q - 4'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            sync     <= '0;
            hist     <= 1'b0;
            count_q  <= 4'b0000;
            borrow_q <= 1'b0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], Count};
            hist     <= sync[SYNC_STAGES-1];
            count_q  <= count_d;
            borrow_q <= borrow_d;
        end
    end

    assign {A3, A2, A1, A0} = count_q;
    assign Borrow           = borrow_q;
    assign Zero             = (count_q == 4'b0000);

endmodule

// File: tb/tb_sync_down_counter_4bit.sv
// -----------------------------------------------------------------------------
// tb_sync_down_counter_4bit
//
// Directed self-checking bench for sync_down_counter_4bit (SYNC_STAGES = 2).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point. A Count fall applied there is captured on the next edge k and
// updates A on edge k+2, i.e. three ticks after the fall is applied.
// -----------------------------------------------------------------------------
module tb_sync_down_counter_4bit;

    logic       clk;
    logic       reset;
    logic       count;
    logic       load;
    logic [3:0] d;
    logic       auto_reload;
    wire        a3, a2, a1, a0;
    wire        borrow;
    wire        zero;
    logic [3:0] a;

    int n_checks = 0;
    int n_fail   = 0;

    assign a = {a3, a2, a1, a0};

    sync_down_counter_4bit #(.SYNC_STAGES(2)) dut (
        .CLK         (clk),
        .Reset       (reset),
        .Count       (count),
        .Load        (load),
        .D3          (d[3]),
        .D2          (d[2]),
        .D1          (d[1]),
        .D0          (d[0]),
        .Auto_Reload (auto_reload),
        .A3          (a3),
        .A2          (a2),
        .A1          (a1),
        .A0          (a0),
        .Borrow      (borrow),
        .Zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] val);
        load = 1'b1;
        d    = val;
        tick(1);
        load = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; count = 1'b0; load = 1'b0; d = 4'b0000; auto_reload = 1'b0;
        tick(3);
        n_checks++;
        if (a !== 4'b0000 || borrow !== 1'b0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: A=%b Borrow=%b Zero=%b, need A=0000 Borrow=0 Zero=1", a, borrow, zero);
        end
        reset = 1'b0;
        tick(6);
        n_checks++;
        if (a !== 4'b0000 || borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_count_low_no_event: A=%b Borrow=%b, need A=0000 Borrow=0", a, borrow);
        end
    endtask

    task automatic test_countdown;
        do_load(4'b0101);
        n_checks++;
        if (a !== 4'b0101) begin
            n_fail++;
            $display("FAIL load_0101: A=%b, need 0101", a);
        end
        count = 1'b1;
        tick(5);
        for (int i = 0; i < 5; i++) begin
            count = 1'b0;
            tick(2);
            n_checks++;
            if (a !== 4'(5 - i)) begin
                n_fail++;
                $display("FAIL countdown_latency_%0d: A=%b, need %b", i, a, 4'(5 - i));
            end
            tick(1);
            n_checks++;
            if (a !== 4'(4 - i) || borrow !== 1'b0) begin
                n_fail++;
                $display("FAIL countdown_step_%0d: A=%b Borrow=%b, need A=%b Borrow=0", i, a, borrow, 4'(4 - i));
            end
            tick(4);
            count = 1'b1;
            tick(5);
        end
        n_checks++;
        if (a !== 4'b0000 || zero !== 1'b1 || borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL countdown_end: A=%b Zero=%b Borrow=%b, need 0000/1/0", a, zero, borrow);
        end
    endtask

    task automatic test_underflow;
        auto_reload = 1'b0;
        count = 1'b0;
        tick(3);
        n_checks++;
        if (a !== 4'b1111 || borrow !== 1'b1 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_1111: A=%b Borrow=%b Zero=%b, need 1111/1/0", a, borrow, zero);
        end
        tick(1);
        n_checks++;
        if (a !== 4'b1111 || borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_borrow_width: A=%b Borrow=%b, need 1111/0", a, borrow);
        end
        count = 1'b1;
        tick(5);
        do_load(4'b0000);
        auto_reload = 1'b1;
        d = 4'b1001;
        count = 1'b0;
        tick(3);
        n_checks++;
        if (a !== 4'b1001 || borrow !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_1001: A=%b Borrow=%b, need 1001/1", a, borrow);
        end
        tick(1);
        n_checks++;
        if (a !== 4'b1001 || borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_borrow_width: A=%b Borrow=%b, need 1001/0", a, borrow);
        end
        count = 1'b1;
        tick(5);
        // Auto-reload with D = 0000: every event underflows again.
        do_load(4'b0000);
        for (int i = 0; i < 2; i++) begin
            count = 1'b0;
            tick(3);
            n_checks++;
            if (a !== 4'b0000 || borrow !== 1'b1) begin
                n_fail++;
                $display("FAIL reload_zero_%0d: A=%b Borrow=%b, need 0000/1", i, a, borrow);
            end
            tick(1);
            n_checks++;
            if (borrow !== 1'b0) begin
                n_fail++;
                $display("FAIL reload_zero_width_%0d: Borrow=%b, need 0", i, borrow);
            end
            count = 1'b1;
            tick(5);
        end
        auto_reload = 1'b0;
    endtask

    task automatic test_load_priority;
        do_load(4'b0111);
        count = 1'b0;
        tick(2);
        load = 1'b1;
        d    = 4'b0011;
        tick(1);
        load = 1'b0;
        n_checks++;
        if (a !== 4'b0011 || borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL load_over_event: A=%b Borrow=%b, need 0011/0", a, borrow);
        end
        tick(3);
        n_checks++;
        if (a !== 4'b0011) begin
            n_fail++;
            $display("FAIL load_event_discarded: A=%b, need 0011", a);
        end
        count = 1'b1;
        tick(5);
    endtask

    task automatic test_reset_count_high;
        count = 1'b1;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(4);
        n_checks++;
        if (a !== 4'b0000 || borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_high_no_false_event: A=%b Borrow=%b, need 0000/0", a, borrow);
        end
        count = 1'b0;
        tick(3);
        n_checks++;
        if (a !== 4'b1111 || borrow !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_high_first_fall: A=%b Borrow=%b, need 1111/1", a, borrow);
        end
        tick(5);
        n_checks++;
        if (a !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_high_single_event: A=%b, need 1111", a);
        end
        count = 1'b1;
        tick(5);
    endtask

    task automatic test_reset_midflight;
        do_load(4'b0110);
        count = 1'b0;
        tick(1);
        reset = 1'b1;
        load  = 1'b1;
        d     = 4'b1010;
        tick(1);
        reset = 1'b0;
        load  = 1'b0;
        n_checks++;
        if (a !== 4'b0000 || borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midflight: A=%b Borrow=%b, need 0000/0", a, borrow);
        end
        tick(6);
        n_checks++;
        if (a !== 4'b0000 || borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midflight_discard: A=%b Borrow=%b, need 0000/0", a, borrow);
        end
        count = 1'b1;
        tick(5);
    endtask

    task automatic test_glitch_and_wrap;
        int nb;
        do_load(4'b0101);
        count = 1'b0;
        tick(1);
        count = 1'b1;
        tick(8);
        n_checks++;
        if (a !== 4'b0101 && a !== 4'b0100) begin
            n_fail++;
            $display("FAIL glitch_single: A=%b, need 0101 or 0100", a);
        end
        auto_reload = 1'b0;
        do_load(4'b0000);
        nb = 0;
        for (int i = 0; i < 16; i++) begin
            count = 1'b0;
            repeat (5) begin
                tick(1);
                if (borrow === 1'b1) nb++;
            end
            if (i == 0) begin
                n_checks++;
                if (a !== 4'b1111 || nb != 1) begin
                    n_fail++;
                    $display("FAIL wrap16_first: A=%b borrows=%0d, need 1111/1", a, nb);
                end
            end
            count = 1'b1;
            repeat (5) begin
                tick(1);
                if (borrow === 1'b1) nb++;
            end
        end
        n_checks++;
        if (a !== 4'b0000 || nb != 1 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap16_end: A=%b borrows=%0d Zero=%b, need 0000/1/1", a, nb, zero);
        end
    endtask

    initial begin
        reset = 1'b1; count = 1'b0; load = 1'b0; d = 4'b0000; auto_reload = 1'b0;
        test_reset;
        test_countdown;
        test_underflow;
        test_load_priority;
        test_reset_count_high;
        test_reset_midflight;
        test_glitch_and_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
